// File: rtl/hadamard_fft_sequencer.sv
// Radix-4 in-place DIF FFT sequencer: walks stages and groups, gathers four samples and
// twiddles per group, hands them to a shared butterfly core and writes its results back.
module hadamard_fft_sequencer #(
  parameter int formatWidth   = 9,
  parameter int logPoints     = 6,
  parameter int timeoutCycles = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fft_start,
  output logic                     fft_busy,
  output logic                     fft_done,
  output logic                     core_error,
  output logic                     mem_rd_en,
  output logic [logPoints-1:0]     mem_rd_addr,
  input  logic [formatWidth-1:0]   mem_rd_real,
  input  logic [formatWidth-1:0]   mem_rd_imag,
  output logic                     mem_wr_en,
  output logic [logPoints-1:0]     mem_wr_addr,
  output logic [formatWidth-1:0]   mem_wr_real,
  output logic [formatWidth-1:0]   mem_wr_imag,
  output logic                     tw_rd_en,
  output logic [logPoints-1:0]     tw_addr,
  input  logic [4*formatWidth-1:0] tw_real,
  input  logic [4*formatWidth-1:0] tw_imag,
  output logic                     core_start,
  output logic [4*formatWidth-1:0] core_in_real,
  output logic [4*formatWidth-1:0] core_in_imag,
  output logic [4*formatWidth-1:0] core_tw_real,
  output logic [4*formatWidth-1:0] core_tw_imag,
  input  logic [4*formatWidth-1:0] core_out_real,
  input  logic [4*formatWidth-1:0] core_out_imag,
  input  logic                     core_done
);
  localparam int FW = formatWidth;
  localparam int LP = logPoints;
  localparam int S  = LP / 2;
  localparam int GW = LP - 2;
  localparam int TW = $clog2(timeoutCycles + 1);

  typedef enum logic [2:0] {IDLE, RD, CAP, LAUNCH, WAIT, WR, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]          s_cnt, k_cnt;
  logic [GW-1:0]       g_cnt;
  logic [TW-1:0]       wait_cnt;
  logic [3:0][FW-1:0]  in_re, in_im, twr_q, twi_q, res_re, res_im;

  logic last_k, last_g, last_s, timeout;
  assign last_k  = (k_cnt == 2'd3);
  assign last_g  = &g_cnt;
  assign last_s  = (s_cnt == 2'(S - 1));
  assign timeout = (wait_cnt == TW'(timeoutCycles - 1));

  // Element address: span = N >> 2(s+1); addr = blk*4*span + off + k*span, via shifts/masks
  logic [3:0]    sh;
  logic [LP-1:0] g_w, span_mask, addr_k;
  always_comb begin
    sh        = 4'(LP - 2) - {1'b0, s_cnt, 1'b0};
    g_w       = LP'(g_cnt);
    span_mask = (LP'(1) << sh) - LP'(1);
    addr_k    = ((g_w >> sh) << (sh + 4'd2)) | (g_w & span_mask) | (LP'(k_cnt) << sh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fft_start) state_nx = RD;
      RD:      if (last_k) state_nx = CAP;
      CAP:     state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (core_done) state_nx = WR;
               else if (timeout) state_nx = IDLE;
      WR:      if (last_k) state_nx = (last_s && last_g) ? DONE : RD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt      <= '0;
      g_cnt      <= '0;
      k_cnt      <= '0;
      wait_cnt   <= '0;
      core_error <= 1'b0;
      in_re      <= '0;
      in_im      <= '0;
      twr_q      <= '0;
      twi_q      <= '0;
      res_re     <= '0;
      res_im     <= '0;
    end else begin
      case (state)
        IDLE: if (fft_start) begin
          s_cnt      <= '0;
          g_cnt      <= '0;
          k_cnt      <= '0;
          core_error <= 1'b0;
        end
        RD: begin
          k_cnt <= k_cnt + 2'd1;
          // RAM data lags the strobe by one cycle, so this cycle holds element k-1
          if (k_cnt != 2'd0) begin
            in_re[k_cnt - 2'd1] <= mem_rd_real;
            in_im[k_cnt - 2'd1] <= mem_rd_imag;
          end
          if (k_cnt == 2'd1) begin
            twr_q <= tw_real;
            twi_q <= tw_imag;
          end
        end
        CAP: begin
          in_re[3] <= mem_rd_real;
          in_im[3] <= mem_rd_imag;
        end
        LAUNCH: wait_cnt <= '0;
        WAIT: begin
          if (core_done) begin
            res_re <= core_out_real;
            res_im <= core_out_imag;
          end else if (timeout) begin
            core_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        WR: begin
          k_cnt <= k_cnt + 2'd1;
          if (last_k) begin
            if (last_g) begin
              g_cnt <= '0;
              s_cnt <= s_cnt + 2'd1;
            end else begin
              g_cnt <= g_cnt + GW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fft_busy     = (state == RD) || (state == CAP) || (state == LAUNCH) ||
                        (state == WAIT) || (state == WR);
  assign fft_done     = (state == DONE);
  assign mem_rd_en    = (state == RD);
  assign mem_rd_addr  = addr_k;
  assign tw_rd_en     = (state == RD) && (k_cnt == 2'd0);
  assign tw_addr      = {s_cnt, g_cnt};
  assign mem_wr_en    = (state == WR);
  assign mem_wr_addr  = addr_k;
  assign mem_wr_real  = res_re[k_cnt];
  assign mem_wr_imag  = res_im[k_cnt];
  assign core_start   = (state == LAUNCH);
  assign core_in_real = in_re;
  assign core_in_imag = in_im;
  assign core_tw_real = twr_q;
  assign core_tw_imag = twi_q;
endmodule

// File: tb/tb_hadamard_fft_sequencer.sv
// Bench for hadamard_fft_sequencer: RAM/ROM/core stubs, a cycle-level model of the
// group schedule and addressing, and directed checks for timeout, reset and restart.
module tb_hadamard_fft_sequencer;
  localparam int FW = 9, LP = 6, NP = 64, S = 3, G = 16, L = 5, TO = 64;
  localparam int GRP = 10 + L, TOTAL = S * G * GRP;

  logic clk = 0, rst = 1, fft_start = 0;
  logic fft_busy, fft_done, core_error, mem_rd_en, mem_wr_en, tw_rd_en, core_start;
  logic [LP-1:0] mem_rd_addr, mem_wr_addr, tw_addr;
  logic [FW-1:0] mem_rd_real = '0, mem_rd_imag = '0, mem_wr_real, mem_wr_imag;
  logic [4*FW-1:0] tw_real = '0, tw_imag = '0, core_out_real = '0, core_out_imag = '0;
  logic [4*FW-1:0] core_in_real, core_in_imag, core_tw_real, core_tw_imag;
  logic core_done = 0;

  always #5 clk = ~clk;

  hadamard_fft_sequencer #(.formatWidth(FW), .logPoints(LP), .timeoutCycles(TO)) dut (
    .clk(clk), .rst(rst), .fft_start(fft_start), .fft_busy(fft_busy), .fft_done(fft_done),
    .core_error(core_error), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_real(mem_rd_real), .mem_rd_imag(mem_rd_imag), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_real(mem_wr_real), .mem_wr_imag(mem_wr_imag),
    .tw_rd_en(tw_rd_en), .tw_addr(tw_addr), .tw_real(tw_real), .tw_imag(tw_imag),
    .core_start(core_start), .core_in_real(core_in_real), .core_in_imag(core_in_imag),
    .core_tw_real(core_tw_real), .core_tw_imag(core_tw_imag), .core_out_real(core_out_real),
    .core_out_imag(core_out_imag), .core_done(core_done));

  int compared = 0, mismatched = 0;
  int cyc = 0;
  int mode = 0;          // 0 identity core, 1 in+1 core, 2 core that never finishes
  bit spur_en = 0, do_load = 0, chk_on = 0, pending = 0;
  int run_start = 0, launch_cyc = 0, wr_cnt = 0;
  logic [FW-1:0] ram_re[NP], ram_im[NP], ram0_re[NP], ram0_im[NP];
  logic [LP-1:0] rd_q[$], tw_q[$];
  logic [4*FW-1:0] twl_re_q[$], twl_im_q[$];
  int done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4*FW-1:0] rom_re(input int a);
    logic [4*FW-1:0] r;
    for (int k = 0; k < 4; k++) r[k*FW +: FW] = FW'(a * 4 + k);
    return r;
  endfunction

  function automatic logic [4*FW-1:0] rom_im(input int a);
    logic [4*FW-1:0] r;
    for (int k = 0; k < 4; k++) r[k*FW +: FW] = FW'(511 - (a * 4 + k));
    return r;
  endfunction

  function automatic int addr_of(input int s, input int g, input int k);
    int span;
    span = NP >> (2 * (s + 1));
    return (g / span) * 4 * span + (g % span) + k * span;
  endfunction

  function automatic logic [15:0] outs_or();
    return {|core_in_real, |core_in_imag, |core_tw_real, |core_tw_imag, fft_busy, fft_done,
            core_error, mem_rd_en, |mem_rd_addr, mem_wr_en, |mem_wr_addr, |mem_wr_real,
            |mem_wr_imag, tw_rd_en, |tw_addr, core_start};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Sample RAM (1-cycle read latency) and twiddle ROM
  always @(posedge clk) begin
    if (do_load) begin
      for (int a = 0; a < NP; a++) begin
        ram_re[a] <= ram0_re[a];
        ram_im[a] <= ram0_im[a];
      end
    end else if (mem_wr_en) begin
      ram_re[mem_wr_addr] <= mem_wr_real;
      ram_im[mem_wr_addr] <= mem_wr_imag;
    end
    if (mem_rd_en) begin
      mem_rd_real <= ram_re[mem_rd_addr];
      mem_rd_imag <= ram_im[mem_rd_addr];
    end
    if (tw_rd_en) begin
      tw_real <= rom_re(int'(tw_addr));
      tw_imag <= rom_im(int'(tw_addr));
    end
  end

  // Butterfly core stub: done L cycles after core_start, optional spurious done pulses
  always @(posedge clk) begin
    #1;
    core_done = 0;
    if (!fft_busy) pending = 0;
    if (pending && mode != 2 && cyc == launch_cyc + L) begin
      core_done = 1;
      pending = 0;
      for (int k = 0; k < 4; k++) begin
        core_out_real[k*FW +: FW] = core_in_real[k*FW +: FW] + FW'(mode == 1);
        core_out_imag[k*FW +: FW] = core_in_imag[k*FW +: FW] + FW'(mode == 1);
      end
    end else if (spur_en && (mem_rd_en || mem_wr_en)) begin
      core_done = 1;
      core_out_real = '1;
      core_out_imag = '1;
    end
    if (core_start) begin
      pending = 1;
      launch_cyc = cyc;
    end
  end

  // Logging plus the per-cycle comparison against the schedule model
  always @(negedge clk) begin
    int off, p, grp, ph, s, g, k, inc, a;
    logic e_busy, e_done, e_rd, e_wr, e_tw, e_cs;
    int e_rda, e_wra, e_twa;
    logic [63:0] act, exp;
    logic [4*FW-1:0] x_re, x_im;
    if (mem_rd_en) rd_q.push_back(mem_rd_addr);
    if (tw_rd_en) tw_q.push_back(tw_addr);
    if (core_start) begin
      twl_re_q.push_back(core_tw_real);
      twl_im_q.push_back(core_tw_imag);
    end
    if (mem_wr_en) wr_cnt++;
    if (fft_done) done_q.push_back(cyc);
    if (chk_on) begin
      off = cyc - run_start;
      inc = (mode == 1) ? 1 : 0;
      {e_busy, e_done, e_rd, e_wr, e_tw, e_cs} = '0;
      e_rda = 0; e_wra = 0; e_twa = 0; s = 0; g = 0; k = 0;
      if (off >= 1 && off <= TOTAL) begin
        p = off - 1; grp = p / GRP; ph = p % GRP; s = grp / G; g = grp % G;
        e_busy = 1;
        if (ph < 4) begin
          e_rd = 1; e_rda = addr_of(s, g, ph);
          if (ph == 0) begin e_tw = 1; e_twa = s * G + g; end
        end
        if (ph == 5) e_cs = 1;
        if (ph >= 6 + L) begin k = ph - 6 - L; e_wr = 1; e_wra = addr_of(s, g, k); end
      end else if (off == TOTAL + 1) begin
        e_done = 1;
      end
      act = 64'({fft_busy, fft_done, mem_rd_en, mem_rd_en ? mem_rd_addr : 6'd0, mem_wr_en,
                 mem_wr_en ? mem_wr_addr : 6'd0, tw_rd_en, tw_rd_en ? tw_addr : 6'd0, core_start});
      exp = 64'({e_busy, e_done, e_rd, 6'(e_rda), e_wr, 6'(e_wra), e_tw, 6'(e_twa), e_cs});
      check("ctrl", act, exp);
      if (e_wr) begin
        a = e_wra;
        check("wr_data", 64'({mem_wr_real, mem_wr_imag}),
              64'({FW'(ram0_re[a] + FW'(inc * (s + 1))), FW'(ram0_im[a] + FW'(inc * (s + 1)))}));
      end
      if (e_cs) begin
        for (int j = 0; j < 4; j++) begin
          a = addr_of(s, g, j);
          x_re[j*FW +: FW] = ram0_re[a] + FW'(inc * s);
          x_im[j*FW +: FW] = ram0_im[a] + FW'(inc * s);
        end
        check("core_in_re", 64'(core_in_real), 64'(x_re));
        check("core_in_im", 64'(core_in_imag), 64'(x_im));
        check("core_tw_re", 64'(core_tw_real), 64'(rom_re(s * G + g)));
        check("core_tw_im", 64'(core_tw_imag), 64'(rom_im(s * G + g)));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load();
    @(posedge clk); #1; do_load = 1;
    @(posedge clk); #1; do_load = 0;
  endtask

  task automatic start_run(input bit hold, input bit model);
    @(posedge clk); #1;
    fft_start = 1;
    run_start = cyc;
    chk_on = model;
    if (!hold) begin
      @(posedge clk); #1;
      fft_start = 0;
    end
  endtask

  task automatic wait_done(input int base, output int d);
    int n = 0;
    while (done_q.size() <= base && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_q.size() > base) d = done_q[base];
    else begin
      d = -1;
      compared++; mismatched++;
      $display("FAIL wait_done: no fft_done within %0d cycles", n);
    end
  endtask

  function automatic int ram_bad(input int add);
    int bad = 0;
    for (int a = 0; a < NP; a++)
      if (ram_re[a] !== FW'(ram0_re[a] + FW'(add)) || ram_im[a] !== FW'(ram0_im[a] + FW'(add)))
        bad++;
    return bad;
  endfunction

  initial begin
    int d, d2, rb, tb, wb, db, bad, n, off;
    logic [23:0] lit_rd[3];
    logic [23:0] act24;
    lit_rd[0] = {6'd53, 6'd37, 6'd21, 6'd5};
    lit_rd[1] = {6'd29, 6'd25, 6'd21, 6'd17};
    lit_rd[2] = {6'd23, 6'd22, 6'd21, 6'd20};
    for (int a = 0; a < NP; a++) begin
      ram0_re[a] = FW'(a);
      ram0_im[a] = FW'(200 + a);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 64'(outs_or()), 64'd0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("post_reset_outs", 64'(outs_or()), 64'd0);

    // Run A: identity core, full schedule
    mode = 0; load();
    rb = rd_q.size(); tb = tw_q.size(); wb = wr_cnt; db = done_q.size();
    start_run(0, 1);
    wait_done(db, d);
    check("doneA_cycle", 64'(d - run_start), 64'd721);
    tick(4); chk_on = 0;
    check("writesA", 64'(wr_cnt - wb), 64'd192);
    check("ramA_unchanged", 64'(ram_bad(0)), 64'd0);
    for (int s = 0; s < 3; s++) begin
      n = rb + (s * G + 5) * 4;
      act24 = {rd_q[n+3], rd_q[n+2], rd_q[n+1], rd_q[n]};
      check($sformatf("rd_addr_s%0d_g5", s), 64'(act24), 64'(lit_rd[s]));
      check($sformatf("tw_addr_s%0d_g5", s), 64'(tw_q[tb + s * G + 5]), 64'({2'(s), 4'd5}));
    end

    // Run B: in+1 core; every word gains 3 over 3 stages
    mode = 1; load();
    tb = twl_re_q.size(); db = done_q.size();
    start_run(0, 1);
    wait_done(db, d);
    check("doneB_cycle", 64'(d - run_start), 64'd721);
    tick(4); chk_on = 0;
    check("ramB_plus3", 64'(ram_bad(3)), 64'd0);
    check("tw_s2_g15_re", 64'(twl_re_q[tb + 47]), 64'({9'd191, 9'd190, 9'd189, 9'd188}));
    check("tw_s2_g15_im", 64'(twl_im_q[tb + 47]), 64'({9'd320, 9'd321, 9'd322, 9'd323}));

    // Run C: core never answers -> timeout after 64 WAIT cycles
    mode = 2; load();
    db = done_q.size();
    start_run(0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!core_start && n < 20);
    check("timeout_launch_seen", 64'(core_start), 64'd1);
    bad = 0;
    repeat (64) begin
      @(negedge clk);
      if (!(fft_busy === 1'b1 && core_error === 1'b0 && fft_done === 1'b0)) bad++;
    end
    check("timeout_wait_window", 64'(bad), 64'd0);
    @(negedge clk);
    check("timeout_flag_idle", 64'({core_error, fft_busy, fft_done}), 64'b100);
    tick(3);
    check("timeout_no_done", 64'(done_q.size() - db), 64'd0);
    check("timeout_error_sticky", 64'(core_error), 64'd1);
    @(posedge clk); #1; fft_start = 1;
    @(posedge clk); #1; fft_start = 0;
    @(negedge clk);
    check("error_cleared_on_start", 64'({core_error, fft_busy}), 64'b01);
    rst = 1; tick(1); rst = 0;

    // Run D: reset during the first WR cycle of s=1, g=3
    mode = 0; load();
    start_run(0, 1);
    n = 0;
    do begin
      @(negedge clk); n++;
      off = cyc - run_start;
    end while (!(off >= 1 && (off - 1) / GRP == G + 3 && (off - 1) % GRP == 6 + L) && n < 2000);
    check("wr_s1_g3_reached", 64'(mem_wr_en), 64'd1);
    chk_on = 0;
    rst = 1; #1;
    check("rst_mid_outs", 64'(outs_or()), 64'd0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("rst_next_outs", 64'(outs_or()), 64'd0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (mem_wr_en !== 1'b0 || fft_busy !== 1'b0) bad++;
    end
    check("rst_no_more_writes", 64'(bad), 64'd0);

    // Run E: fft_start held, spurious core_done in RD/WR, immediate second run
    mode = 0; spur_en = 1; load();
    db = done_q.size(); wb = wr_cnt;
    start_run(1, 1);
    wait_done(db, d);
    check("doneE1_cycle", 64'(d - run_start), 64'd721);
    @(posedge clk); #1;
    run_start = run_start + TOTAL + 2;
    wait_done(db + 1, d2);
    fft_start = 0;
    check("doneE2_gap", 64'(d2 - d), 64'd722);
    tick(5); chk_on = 0; spur_en = 0;
    check("writesE", 64'(wr_cnt - wb), 64'd384);
    check("ramE_unchanged", 64'(ram_bad(0)), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
